branch_resolve_queue: RTL and testbench

//  Tracks every conditional branch from decode (predict time) to memory stage (resolve time).

---
 rtl/branch_resolve_queue_pkg.sv | 23 ++
 rtl/brq_fifo.sv | 62 ++++++
 rtl/branch_resolve_queue.sv | 96 +++++++++
 tb/tb_branch_resolve_queue.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch resolve queue.
// Entry layout, PC increment and default queue depth.
package branch_resolve_queue_pkg;

    localparam int BRQ_ENTRY_W   = 65;
    localparam int BRQ_PRED_OFF  = 0;
    localparam int BRQ_TGT_LSB   = 1;
    localparam int BRQ_PC_LSB    = 33;
    localparam int BRQ_DEPTH_DEF = 4;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred_taken;
    } brq_entry_t;

    function automatic logic [31:0] fall_through(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/brq_fifo.sv
// Register-array FIFO holding in-flight branches.
// Flush empties the queue while still consuming the head entry.
module brq_fifo import branch_resolve_queue_pkg::*; #(
    parameter int DEPTH = BRQ_DEPTH_DEF,
    parameter int W     = BRQ_ENTRY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A push into a full queue is legal when the head leaves the same cycle
    assign push_ok = push && !flush && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (flush) begin
                count  <= '0;
                wr_ptr <= rd_ptr + PW'(1);
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                count <= count + CW'(push_ok) - CW'(pop_ok);
            end
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks branches from decode to memory stage, flags mispredicts,
// drives predictor updates and keeps saturating hit/miss statistics.
module branch_resolve_queue import branch_resolve_queue_pkg::*; #(
    parameter int DEPTH = BRQ_DEPTH_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch_decode_sig,
    input  logic             pred_taken,
    input  logic [31:0]      push_pc,
    input  logic [31:0]      push_target,
    input  logic             branch_mem_sig,
    input  logic             actual_taken,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             update_valid,
    output logic [31:0]      update_branch_addr,
    output logic             update_decision,
    output logic             q_full,
    output logic             q_empty,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    brq_entry_t push_entry;
    brq_entry_t head;
    logic       pop_ok;
    logic       mis;
    logic       ovf;
    logic       unf;

    assign push_entry = '{pc: push_pc,
                          target: push_target,
                          pred_taken: pred_taken};

    assign pop_ok = branch_mem_sig && !q_empty;
    assign mis    = pop_ok && (head.pred_taken ^ actual_taken);
    assign ovf    = branch_decode_sig && q_full && !pop_ok;
    assign unf    = branch_mem_sig && q_empty;

    brq_fifo #(
        .DEPTH (DEPTH),
        .W     (BRQ_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (branch_decode_sig),
        .pop   (branch_mem_sig),
        .flush (mis),
        .wdata (push_entry),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mispredict         <= 1'b0;
            redirect_pc        <= '0;
            update_valid       <= 1'b0;
            update_branch_addr <= '0;
            update_decision    <= 1'b0;
            err_overflow       <= 1'b0;
            err_underflow      <= 1'b0;
            stat_branches      <= '0;
            stat_mispredicts   <= '0;
        end else begin
            mispredict   <= mis;
            update_valid <= pop_ok;
            if (pop_ok) begin
                update_branch_addr <= head.pc;
                update_decision    <= actual_taken;
                if (stat_branches != '1) begin
                    stat_branches <= stat_branches + CNT_W'(1);
                end
            end
            if (mis) begin
                redirect_pc <= actual_taken ? head.target
                                            : fall_through(head.pc);
                if (stat_mispredicts != '1) begin
                    stat_mispredicts <= stat_mispredicts + CNT_W'(1);
                end
            end
            if (ovf) begin
                err_overflow <= 1'b1;
            end
            if (unf) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue (32-bit and 4-bit counter builds).
// Stimulus pushes expected resolve records; a negedge monitor checks them.
module tb_branch_resolve_queue;
    import branch_resolve_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_decode_sig;
    logic        pred_taken;
    logic [31:0] push_pc;
    logic [31:0] push_target;
    logic        branch_mem_sig;
    logic        actual_taken;

    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        update_valid;
    logic [31:0] update_branch_addr;
    logic        update_decision;
    logic        q_full;
    logic        q_empty;
    logic        err_overflow;
    logic        err_underflow;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    logic        mispredict4;
    logic [31:0] redirect_pc4;
    logic        update_valid4;
    logic [31:0] update_branch_addr4;
    logic        update_decision4;
    logic        q_full4;
    logic        q_empty4;
    logic        err_overflow4;
    logic        err_underflow4;
    logic [3:0]  stat_branches4;
    logic [3:0]  stat_mispredicts4;

    branch_resolve_queue #(.DEPTH(4), .CNT_W(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .branch_decode_sig  (branch_decode_sig),
        .pred_taken         (pred_taken),
        .push_pc            (push_pc),
        .push_target        (push_target),
        .branch_mem_sig     (branch_mem_sig),
        .actual_taken       (actual_taken),
        .mispredict         (mispredict),
        .redirect_pc        (redirect_pc),
        .update_valid       (update_valid),
        .update_branch_addr (update_branch_addr),
        .update_decision    (update_decision),
        .q_full             (q_full),
        .q_empty            (q_empty),
        .err_overflow       (err_overflow),
        .err_underflow      (err_underflow),
        .stat_branches      (stat_branches),
        .stat_mispredicts   (stat_mispredicts)
    );

    branch_resolve_queue #(.DEPTH(4), .CNT_W(4)) dut4 (
        .clk                (clk),
        .rst_n              (rst_n),
        .branch_decode_sig  (branch_decode_sig),
        .pred_taken         (pred_taken),
        .push_pc            (push_pc),
        .push_target        (push_target),
        .branch_mem_sig     (branch_mem_sig),
        .actual_taken       (actual_taken),
        .mispredict         (mispredict4),
        .redirect_pc        (redirect_pc4),
        .update_valid       (update_valid4),
        .update_branch_addr (update_branch_addr4),
        .update_decision    (update_decision4),
        .q_full             (q_full4),
        .q_empty            (q_empty4),
        .err_overflow       (err_overflow4),
        .err_underflow      (err_underflow4),
        .stat_branches      (stat_branches4),
        .stat_mispredicts   (stat_mispredicts4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic        dec;
        logic        mis;
        logic [31:0] redir;
    } exp_t;

    exp_t       sb[$];
    brq_entry_t mq[$];

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          armed = 1'b0;
    logic        m_ovf;
    logic        m_unf;
    logic [31:0] m_addr;
    logic        m_dec;
    logic [31:0] m_redir;
    logic [31:0] m_sb;
    logic [31:0] m_sm;
    logic [3:0]  m_sb4;
    logic [3:0]  m_sm4;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        mq.delete();
        m_ovf = 0; m_unf = 0;
        m_addr = 0; m_dec = 0; m_redir = 0;
        m_sb = 0; m_sm = 0; m_sb4 = 0; m_sm4 = 0;
    endtask

    task automatic idle_inputs();
        branch_decode_sig = 0; pred_taken = 0;
        push_pc = 0; push_target = 0;
        branch_mem_sig = 0; actual_taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        @(posedge clk);
        model_clear();
        #1 rst_n = 1;
        armed = 1'b1;
    endtask

    task automatic step(input logic psh, input logic pred,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pp, input logic act);
        int         due;
        brq_entry_t e;
        logic       full;
        logic       pop_ok;
        logic       mis;
        branch_decode_sig = psh; pred_taken = pred;
        push_pc = pc; push_target = tgt;
        branch_mem_sig = pp; actual_taken = act;
        due = cyc + 1;
        @(posedge clk);
        full   = (mq.size() == 4);
        pop_ok = pp && (mq.size() != 0);
        mis    = 0;
        if (pp && !pop_ok) m_unf = 1;
        if (pop_ok) begin
            e   = mq.pop_front();
            mis = e.pred_taken ^ act;
            m_addr = e.pc;
            m_dec  = act;
            if (mis) m_redir = act ? e.target : e.pc + 32'd4;
            sb.push_back('{due, e.pc, act, mis, m_redir});
            if (m_sb != 32'hFFFF_FFFF) m_sb = m_sb + 1;
            if (m_sb4 != 4'hF) m_sb4 = m_sb4 + 1;
            if (mis) begin
                if (m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 1;
                if (m_sm4 != 4'hF) m_sm4 = m_sm4 + 1;
                mq.delete();
            end
        end
        if (psh && !mis) begin
            if (full && !pop_ok) m_ovf = 1;
            else mq.push_back('{pc: pc, target: tgt, pred_taken: pred});
        end
        #1 idle_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("update_valid", update_valid, 1);
                chk("update_addr", update_branch_addr, e.addr);
                chk("update_decision", update_decision, e.dec);
                chk("mispredict", mispredict, e.mis);
                if (e.mis) chk("redirect_pc", redirect_pc, e.redir);
            end else begin
                chk("idle_update_valid", update_valid, 0);
                chk("idle_mispredict", mispredict, 0);
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    chk("missed_resolve_due", sb[0].due, cyc);
                    void'(sb.pop_front());
                end
            end
            chk("held_addr", update_branch_addr, m_addr);
            chk("held_redirect", redirect_pc, m_redir);
            chk("q_empty", q_empty, mq.size() == 0);
            chk("q_full", q_full, mq.size() == 4);
            chk("err_overflow", err_overflow, m_ovf);
            chk("err_underflow", err_underflow, m_unf);
            chk("stat_branches", stat_branches, m_sb);
            chk("stat_mispredicts", stat_mispredicts, m_sm);
            chk("stat_branches4", stat_branches4, m_sb4);
            chk("stat_mispredicts4", stat_mispredicts4, m_sm4);
            chk("mispredict4", mispredict4, mispredict);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 do_reset();

        // 1: reset with stale entries
        step(1, 1, 32'h10, 32'h20, 0, 0);
        step(1, 0, 32'h14, 32'h24, 0, 0);
        step(1, 1, 32'h18, 32'h28, 0, 0);
        do_reset();
        @(negedge clk);
        chk("rst_q_empty", q_empty, 1);
        chk("rst_update_valid", update_valid, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_stat_branches", stat_branches, 0);
        @(posedge clk);
        #1;

        // 2: correct taken prediction
        step(1, 1, 32'h100, 32'h140, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        idle(1);

        // 3: taken predicted, not taken actual
        step(1, 1, 32'h200, 32'h180, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        idle(1);

        // 4: flush discards younger entries and a same-cycle push
        step(1, 0, 32'h300, 32'h340, 0, 0);
        step(1, 1, 32'h304, 32'h380, 0, 0);
        step(1, 0, 32'h308, 32'h390, 0, 0);
        step(1, 1, 32'h30C, 32'h3A0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        idle(1);

        // 5: full, overflow, wrap with simultaneous push/pop
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1, i[0], 32'h400 + 32'(i * 4), 32'h500, 0, 0);
        step(1, 1, 32'h4F0, 32'h500, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 1, 32'h600 + 32'(i * 4), 32'h700, 1, i[0]);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 1, 1);
        idle(1);

        // 6: redirect wraps to zero, then drive 4-bit counters to saturation
        step(1, 1, 32'hFFFF_FFFC, 32'h10, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 32'h800 + 32'(i * 4), 32'h900, 0, 0);
            step(0, 0, 0, 0, 1, (i % 3) != 0);
        end
        idle(2);

        chk("sb_drained", sb.size(), 0);
        chk("sat_branches4", stat_branches4, 4'hF);
        chk("branches32", stat_branches, 32'd19);
        chk("mispredicts4", stat_mispredicts4, 4'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
